multi_clock_divider: RTL

- Parametrised successor to the single-output divider: NUM_CH independent divided clocks from one fast input clock.
- Each channel has runtime-programmable high and low phase lengths, so duty cycle is arbitrary.
- Configuration changes are glitch-free; each channel can be started and stopped cleanly.
- Provides per-channel rising-edge strobes and a sticky locked flag; sits between the board clock and the CPU/peripheral clock domains.

---
 rtl/multi_clock_divider.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider.
// Every channel produces a divided clock from inclk0 with independently
// programmable high/low phase lengths, a one-cycle rising-edge strobe, clean
// start/stop, and a one-deep pending configuration slot that is applied only
// at a period boundary so the output never glitches.
module multi_clock_divider #(
    parameter int BIT_WIDTH  = 32,
    parameter int NUM_CH     = 2,
    parameter int CH_W       = 1,
    parameter int DEFAULT_HI = 200,
    parameter int DEFAULT_LO = 200
) (
    input  logic                 inclk0,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    ch_en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [BIT_WIDTH-1:0] cfg_hi,
    input  logic [BIT_WIDTH-1:0] cfg_lo,
    output logic [NUM_CH-1:0]    c0,
    output logic [NUM_CH-1:0]    rise,
    output logic                 locked
);

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_HIGH = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam logic [BIT_WIDTH-1:0] RST_HI = BIT_WIDTH'(DEFAULT_HI);
    localparam logic [BIT_WIDTH-1:0] RST_LO = BIT_WIDTH'(DEFAULT_LO);

    logic [NUM_CH-1:0] pend_vld;
    logic [NUM_CH-1:0] seen_rise;
    logic              locked_reg;

    // Slot for the addressed channel is free; out-of-range channels always accept (and drop).
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pend_vld[i];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        state_t                 state_reg, state_next;
        logic [BIT_WIDTH-1:0]   cnt_reg, cnt_next;
        logic [BIT_WIDTH-1:0]   hi_reg, hi_next;
        logic [BIT_WIDTH-1:0]   lo_reg, lo_next;
        logic [BIT_WIDTH-1:0]   pend_hi_reg, pend_hi_next;
        logic [BIT_WIDTH-1:0]   pend_lo_reg, pend_lo_next;
        logic                   pend_vld_reg, pend_vld_next;
        logic                   c0_reg, c0_next;
        logic                   rise_reg, rise_next;
        logic                   seen_reg, seen_next;
        logic                   wr;
        logic                   apply;
        logic [BIT_WIDTH-1:0]   eff_hi;
        logic [BIT_WIDTH-1:0]   eff_lo;

        assign wr     = cfg_valid && cfg_ready && (cfg_ch == CH_W'(gi));
        // Values that will be active once a boundary consumes the pending slot.
        assign eff_hi = pend_vld_reg ? pend_hi_reg : hi_reg;
        assign eff_lo = pend_vld_reg ? pend_lo_reg : lo_reg;

        // Next-state and output logic: phase counting, boundary apply, pending slot update.
        always_comb begin
            state_next    = state_reg;
            cnt_next      = cnt_reg;
            hi_next       = hi_reg;
            lo_next       = lo_reg;
            c0_next       = c0_reg;
            rise_next     = 1'b0;
            seen_next     = seen_reg;
            pend_vld_next = pend_vld_reg;
            pend_hi_next  = pend_hi_reg;
            pend_lo_next  = pend_lo_reg;
            apply         = 1'b0;
            case (state_reg)
                ST_LOW: begin
                    if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - BIT_WIDTH'(1);
                    end else if (ch_en[gi]) begin
                        apply      = 1'b1;
                        hi_next    = eff_hi;
                        lo_next    = eff_lo;
                        cnt_next   = eff_hi;
                        c0_next    = 1'b1;
                        rise_next  = 1'b1;
                        seen_next  = 1'b1;
                        state_next = ST_HIGH;
                    end else begin
                        c0_next    = 1'b0;
                        state_next = ST_STOP;
                    end
                end
                ST_HIGH: begin
                    // Enable is ignored here so a high pulse is never cut short.
                    if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - BIT_WIDTH'(1);
                    end else begin
                        c0_next    = 1'b0;
                        cnt_next   = lo_reg;
                        state_next = ST_LOW;
                    end
                end
                ST_STOP: begin
                    c0_next = 1'b0;
                    if (ch_en[gi]) begin
                        apply      = 1'b1;
                        hi_next    = eff_hi;
                        lo_next    = eff_lo;
                        cnt_next   = eff_lo;
                        state_next = ST_LOW;
                    end
                end
                default: begin
                    c0_next    = 1'b0;
                    cnt_next   = lo_reg;
                    state_next = ST_LOW;
                end
            endcase
            // Apply frees the slot first, so a same-cycle write lands in it.
            if (apply) begin
                pend_vld_next = 1'b0;
            end
            if (wr) begin
                pend_vld_next = 1'b1;
                pend_hi_next  = cfg_hi;
                pend_lo_next  = cfg_lo;
            end
        end

        // Channel state register with synchronous reset to the default divide ratio.
        always_ff @(posedge inclk0) begin
            if (rst) begin
                state_reg    <= ST_LOW;
                cnt_reg      <= RST_LO;
                hi_reg       <= RST_HI;
                lo_reg       <= RST_LO;
                pend_hi_reg  <= '0;
                pend_lo_reg  <= '0;
                pend_vld_reg <= 1'b0;
                c0_reg       <= 1'b0;
                rise_reg     <= 1'b0;
                seen_reg     <= 1'b0;
            end else begin
                state_reg    <= state_next;
                cnt_reg      <= cnt_next;
                hi_reg       <= hi_next;
                lo_reg       <= lo_next;
                pend_hi_reg  <= pend_hi_next;
                pend_lo_reg  <= pend_lo_next;
                pend_vld_reg <= pend_vld_next;
                c0_reg       <= c0_next;
                rise_reg     <= rise_next;
                seen_reg     <= seen_next;
            end
        end

        assign c0[gi]        = c0_reg;
        assign rise[gi]      = rise_reg;
        assign pend_vld[gi]  = pend_vld_reg;
        assign seen_rise[gi] = seen_reg;
    end

    // Sticky lock: every enabled channel has delivered at least one rising edge.
    always_ff @(posedge inclk0) begin
        if (rst) begin
            locked_reg <= 1'b0;
        end else if (&(seen_rise | ~ch_en)) begin
            locked_reg <= 1'b1;
        end
    end

    assign locked = locked_reg;

endmodule
